td4_prog_loader: RTL

//  UART program loader sitting directly upstream of the TD4 16-entry program memory.

---
 rtl/td4_pkg.sv | 28 ++
 rtl/td4_prog_loader_if.sv | 20 ++
 rtl/td4_uart_rx.sv | 113 +++++++++++
 rtl/td4_prog_loader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program loader.
//   loader_state_t : top-level loader FSM states
//   rx_state_t     : UART receiver FSM states
//   OPC_W/IMM_W    : opcode / immediate nibble widths
//   BYTE_W         : UART data byte width
package td4_pkg;

  localparam int OPC_W  = 4;
  localparam int IMM_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    LOAD_IDLE,
    LOAD_RX,
    COMMIT,
    CHECK,
    DONE
  } loader_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Write port into the TD4 program memory.
//   mem_we     : one-cycle write strobe
//   mem_addr   : write address
//   mem_opcode : opcode nibble of the written byte
//   mem_imm    : immediate nibble of the written byte
// master = loader side (drives), slave = memory side (receives).
interface td4_prog_loader_if #(
  parameter int ADDR_W = 4
);
  import td4_pkg::*;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [OPC_W-1:0]  mem_opcode;
  logic [IMM_W-1:0]  mem_imm;

  modport master (output mem_we, mem_addr, mem_opcode, mem_imm);
  modport slave  (input  mem_we, mem_addr, mem_opcode, mem_imm);

endinterface

// File: rtl/td4_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, down-counting bit timer, LSB-first
// shift register.
//   clk, rst_n    : clock, async active-low reset
//   rx_i          : raw UART line (idle high)
//   abort_i       : drop any byte in progress and return to idle
//   byte_o        : received byte (valid with byte_valid_o)
//   byte_valid_o  : 1-cycle pulse, stop bit sampled 1
//   frame_err_o   : 1-cycle pulse, stop bit sampled 0
//   busy_o        : a frame is being received
//
// state        | meaning
// RX_IDLE      | waiting for a falling edge on the synchronized line
// RX_START     | timing half a bit to re-check the start bit
// RX_DATA      | sampling 8 data bits, one per bit period
// RX_STOP      | sampling the stop bit
// RX_WAIT_HIGH | bad stop bit; wait for the line to return high
module td4_uart_rx
  import td4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  input  logic              abort_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t         state_q, state_d;
  logic              rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tick;

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d = RX_START;
          cnt_d   = CNT_HALF;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_sync) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = CNT_FULL;
            bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_d = {rx_sync, shift_q[BYTE_W-1:1]};
          cnt_d   = CNT_FULL;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) state_d = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
    if (abort_i) state_d = RX_IDLE;
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = (state_q == RX_STOP) && tick && rx_sync;
  assign frame_err_o  = (state_q == RX_STOP) && tick && !rx_sync;
  assign busy_o       = (state_q == RX_START) || (state_q == RX_DATA) ||
                        (state_q == RX_STOP);

endmodule

// File: rtl/td4_prog_loader.sv
// UART program loader for the TD4 16-entry program memory. Each received byte
// is written as {opcode, imm} at consecutive addresses; the CPU is released
// (cpu_run_o) only once a complete image has been loaded.
// Optional feature macro: TD4_LOADER_CHECKSUM_EN -- one extra byte after the
// image must equal the XOR of all image bytes before the CPU is released.
//   clk, rst_n   : clock, async active-low reset
//   rx_i         : UART line (8N1, idle high)
//   load_req_i   : level, restart loading at address 0 while high
//   mem          : memory write port (master)
//   cpu_run_o    : image complete, CPU may run
//   busy_o       : loader is in a loading state
//   frame_err_o  : sticky, a stop bit was sampled low
//   chk_err_o    : sticky, checksum mismatch
//
// state     | meaning
// LOAD_IDLE | waiting for the next byte of the image
// LOAD_RX   | byte reception in progress
// COMMIT    | write strobe for the received byte
// CHECK     | waiting for the checksum byte
// DONE      | image complete, CPU running, further bytes ignored
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  input  logic              load_req_i,
  td4_prog_loader_if.master mem,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              chk_err_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] data_q;
  logic              busy_q;
  logic              frame_err_q;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid, rx_ferr, rx_busy;
  logic              loading;

  td4_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .abort_i     (load_req_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr),
    .busy_o      (rx_busy)
  );

  assign loading = (state_q == LOAD_IDLE) || (state_q == LOAD_RX);

`ifdef TD4_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
  logic              chk_err_q;
  logic              csum_ok;

  assign csum_ok = (rx_byte == csum_q);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_IDLE, LOAD_RX: begin
        if (rx_valid)     state_d = COMMIT;
        else if (rx_busy) state_d = LOAD_RX;
        else              state_d = LOAD_IDLE;
      end
      COMMIT: begin
        if (addr_q != ADDR_MAX) state_d = LOAD_IDLE;
`ifdef TD4_LOADER_CHECKSUM_EN
        else                    state_d = CHECK;
`else
        else                    state_d = DONE;
`endif
      end
`ifdef TD4_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) state_d = csum_ok ? DONE : LOAD_IDLE;
      end
`endif
      DONE:    state_d = DONE;
      default: state_d = LOAD_IDLE;
    endcase
    // A load request overrides everything, including a final commit.
    if (load_req_i) state_d = LOAD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered so busy_o is 0 while in reset and 1 from the first clock.
      busy_q  <= (state_d != DONE);
      if (load_req_i) begin
        addr_q      <= '0;
        frame_err_q <= 1'b0;
      end else begin
        if (rx_ferr) frame_err_q <= 1'b1;
        // Wraps to 0 after the last entry.
        if (state_q == COMMIT) addr_q <= addr_q + 1'b1;
        if (rx_valid && loading) data_q <= rx_byte;
      end
    end
  end

`ifdef TD4_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q    <= '0;
      chk_err_q <= 1'b0;
    end else if (load_req_i) begin
      csum_q    <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (state_q == COMMIT) csum_q <= csum_q ^ data_q;
      if (state_q == CHECK && rx_valid) begin
        csum_q <= '0;
        if (!csum_ok) chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err_o = chk_err_q;
`else
  assign chk_err_o = 1'b0;
`endif

  assign mem.mem_we     = (state_q == COMMIT);
  assign mem.mem_addr   = addr_q;
  assign mem.mem_opcode = data_q[BYTE_W-1:IMM_W];
  assign mem.mem_imm    = data_q[IMM_W-1:0];

  // Drops in the same cycle as a load request.
  assign cpu_run_o   = (state_q == DONE) && !load_req_i;
  assign busy_o      = busy_q;
  assign frame_err_o = frame_err_q;

endmodule
